battle_link: RTL
================

BATTLE_LINK -- requirements
Module: battle_link

Interface
REQ-001 SCORE_W, default 8, score field width in bits.
REQ-002 BOMB_W, default 4, bomb (garbage-line) count field width in bits.
REQ-003 DIV, default 16, bit period in clk cycles; even, >=4.
REQ-004 TIMEOUT, default 50000000, clk cycles without a valid frame before the peer is declared lost.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 pb_in_rst  in  1  reset, synchronous, active-low.
REQ-007 tx_req  in  1  one-cycle request to send current local fields.
REQ-008 tx_stat / tx_score / tx_ko / tx_bomb  in  2 / SCORE_W / 1 / BOMB_W  local game fields.
REQ-009 tx_busy  out  1  frame or inter-frame gap in progress.
REQ-010 con_out_clk_sync / con_out_frame / con_out_data  out  1 each  source-synchronous link to the peer.
REQ-011 con_in_clk_sync / con_in_frame / con_in_data  in  1 each  link from the peer; asynchronous to clk.
REQ-012 rx_stat / rx_score / rx_ko / rx_bomb  out  2 / SCORE_W / 1 / BOMB_W  last valid peer fields.
REQ-013 rx_valid  out  1  one-cycle pulse, new peer fields loaded.
REQ-014 rx_err  out  1  one-cycle pulse, received frame rejected.
REQ-015 peer_alive  out  1  valid frame seen within the last TIMEOUT cycles.

Function
REQ-016 Payload order MSB first: stat, score, ko, bomb; payload length P = 3+SCORE_W+BOMB_W; frame length L = P (+1 parity bit when enabled).
REQ-017 TX FSM states IDLE, SHIFT, GAP; tx_busy = 1 in SHIFT and GAP.
REQ-018 IDLE with tx_req=1: fields latched, next cycle SHIFT, con_out_frame=1.
REQ-019 tx_req while tx_busy=1 is ignored; no queuing.
REQ-020 Each bit lasts DIV cycles: con_out_data stable whole period; con_out_clk_sync low first DIV/2 cycles, high last DIV/2.
REQ-021 After bit L-1: con_out_frame=0, con_out_clk_sync=0, con_out_data=0, GAP for 2*DIV cycles, then IDLE.
REQ-022 RX: each con_in_* passes a 2-flop synchronizer before use.
REQ-023 Synced frame rising edge clears bit counter and shift register.
REQ-024 Synced clk_sync rising edge while synced frame=1 shifts in data bit; counter saturates at L+1.
REQ-025 Synced frame falling edge: counter==L and check passes -> rx_* fields updated and rx_valid=1 next cycle; otherwise rx_err=1 next cycle, rx_* fields unchanged.
REQ-026 rx_valid and rx_err never both 1.
REQ-027 Timeout counter cleared on rx_valid, otherwise increments, saturating at TIMEOUT; peer_alive = 1 while counter < TIMEOUT and at least one valid frame received since reset.
REQ-028 TX and RX are independent; full-duplex operation and loopback (outputs wired to inputs) are required.

Reset
REQ-029 pb_in_rst=0 at a clk edge: TX to IDLE, RX counter and shift register cleared, timeout counter cleared.
REQ-030 Reset values: all outputs 0, including rx_* fields, peer_alive, con_out_*.
REQ-031 Reset mid-frame abandons the frame; a partially received frame after reset is discarded until the next frame rising edge.

Configuration
REQ-032 BATTLE_LINK_PARITY_EN defined: even-parity bit (XOR of payload) appended as bit L-1; RX rejects mismatch with rx_err.
REQ-033 BATTLE_LINK_PARITY_EN undefined: no parity bit, L = P; RX rejects only on length mismatch.

Verification
REQ-034 Loopback, SCORE_W=8, BOMB_W=4, DIV=4, parity on: tx stat=2'b10, score=8'hA5, ko=1, bomb=4'h3 -> L=16, exactly one rx_valid, rx fields equal sent values, tx_busy for 16*4+8 cycles.
REQ-035 Injected frame with parity bit inverted -> one rx_err pulse, no rx_valid, rx fields retain previous values.
REQ-036 Frame dropped after 9 bits; separately, frame held for 17 bits -> rx_err each time, no rx_valid.
REQ-037 tx_req pulsed in SHIFT and in GAP -> no second frame; next tx_req in IDLE sends exactly one frame.
REQ-038 TIMEOUT=100: valid frame then silence -> peer_alive 1 after rx_valid, falls to 0 exactly 100 cycles later.
REQ-039 pb_in_rst=0 asserted mid-frame for one cycle -> all outputs 0 next cycle; a subsequent full frame is received correctly.

Source files
------------

// File: rtl/battle_link.sv
// Full-duplex source-synchronous link carrying stat/score/ko/bomb fields.
// Define BATTLE_LINK_PARITY_EN to append an even-parity bit to each frame.
module battle_link #(
  parameter int SCORE_W = 8,
  parameter int BOMB_W  = 4,
  parameter int DIV     = 16,
  parameter int TIMEOUT = 50000000
) (
  input  logic               clk,
  input  logic               pb_in_rst,
  input  logic               tx_req,
  input  logic [1:0]         tx_stat,
  input  logic [SCORE_W-1:0] tx_score,
  input  logic               tx_ko,
  input  logic [BOMB_W-1:0]  tx_bomb,
  output logic               tx_busy,
  output logic               con_out_clk_sync,
  output logic               con_out_frame,
  output logic               con_out_data,
  input  logic               con_in_clk_sync,
  input  logic               con_in_frame,
  input  logic               con_in_data,
  output logic [1:0]         rx_stat,
  output logic [SCORE_W-1:0] rx_score,
  output logic               rx_ko,
  output logic [BOMB_W-1:0]  rx_bomb,
  output logic               rx_valid,
  output logic               rx_err,
  output logic               peer_alive
);

  localparam int P  = 3 + SCORE_W + BOMB_W;
`ifdef BATTLE_LINK_PARITY_EN
  localparam int L  = P + 1;
`else
  localparam int L  = P;
`endif
  localparam int CW = $clog2(L + 2);
  localparam int KW = $clog2(2 * DIV);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } tx_state_t;

  tx_state_t      state, state_nx;
  logic [KW-1:0]  tick, tick_nx;
  logic [CW-1:0]  bitc, bitc_nx;
  logic [L-1:0]   tx_sh, sh_nx;
  logic [P-1:0]   payload;
  logic [L-1:0]   tx_word;
  logic           bit_end, last_bit, gap_end;
  logic           frame_nx;

  assign payload = {tx_stat, tx_score, tx_ko, tx_bomb};
`ifdef BATTLE_LINK_PARITY_EN
  assign tx_word = {payload, ^payload};
`else
  assign tx_word = payload;
`endif

  assign bit_end  = (tick == KW'(DIV - 1));
  assign last_bit = (bitc == CW'(L - 1));
  assign gap_end  = (tick == KW'(2 * DIV - 1));

  // TX next-state and next datapath values
  always_comb begin
    state_nx = state;
    tick_nx  = tick + 1'b1;
    bitc_nx  = bitc;
    sh_nx    = tx_sh;
    unique case (state)
      IDLE: begin
        tick_nx = '0;
        if (tx_req) begin
          state_nx = SHIFT;
          sh_nx    = tx_word;
          bitc_nx  = '0;
        end
      end
      SHIFT: begin
        if (bit_end) begin
          tick_nx = '0;
          bitc_nx = bitc + 1'b1;
          sh_nx   = tx_sh << 1;
          if (last_bit) state_nx = GAP;
        end
      end
      GAP: begin
        if (gap_end) begin
          state_nx = IDLE;
          tick_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        tick_nx  = '0;
      end
    endcase
    frame_nx = (state_nx == SHIFT);
  end

  // TX state, counters and glitch-free registered link outputs
  always_ff @(posedge clk) begin
    if (!pb_in_rst) begin
      state            <= IDLE;
      tick             <= '0;
      bitc             <= '0;
      tx_sh            <= '0;
      tx_busy          <= 1'b0;
      con_out_frame    <= 1'b0;
      con_out_clk_sync <= 1'b0;
      con_out_data     <= 1'b0;
    end else begin
      state            <= state_nx;
      tick             <= tick_nx;
      bitc             <= bitc_nx;
      tx_sh            <= sh_nx;
      tx_busy          <= (state_nx != IDLE);
      con_out_frame    <= frame_nx;
      con_out_clk_sync <= frame_nx && (tick_nx >= KW'(DIV / 2));
      con_out_data     <= frame_nx && sh_nx[L-1];
    end
  end

  logic [2:0] fr_q, ck_q;
  logic [1:0] dt_q;

  // Synchronizers plus one history stage for edge detection; left
  // unreset so they keep tracking the line through a local reset
  always_ff @(posedge clk) begin
    fr_q <= {fr_q[1:0], con_in_frame};
    ck_q <= {ck_q[1:0], con_in_clk_sync};
    dt_q <= {dt_q[0], con_in_data};
  end

  logic fr_rise, fr_fall, ck_rise;
  assign fr_rise = fr_q[1] & ~fr_q[2];
  assign fr_fall = ~fr_q[1] & fr_q[2];
  assign ck_rise = ck_q[1] & ~ck_q[2];

  logic [CW-1:0] rx_cnt;
  logic [L-1:0]  rx_sh;
  logic          armed;
  logic          got_valid;
  logic [TW-1:0] to_cnt;
  logic          rx_ok;
  logic          accept;

`ifdef BATTLE_LINK_PARITY_EN
  assign rx_ok = (rx_cnt == CW'(L)) && !(^rx_sh);
`else
  assign rx_ok = (rx_cnt == CW'(L));
`endif

  assign accept     = fr_fall && armed && rx_ok;
  assign peer_alive = got_valid && (to_cnt != TW'(TIMEOUT));

  // RX deserializer, frame check and liveness timer
  always_ff @(posedge clk) begin
    if (!pb_in_rst) begin
      rx_cnt    <= '0;
      rx_sh     <= '0;
      armed     <= 1'b0;
      got_valid <= 1'b0;
      to_cnt    <= '0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
      rx_stat   <= '0;
      rx_score  <= '0;
      rx_ko     <= 1'b0;
      rx_bomb   <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (fr_rise) begin
        rx_cnt <= '0;
        rx_sh  <= '0;
        armed  <= 1'b1;
      end else if (ck_rise && fr_q[1] && armed) begin
        rx_sh <= {rx_sh[L-2:0], dt_q[1]};
        if (rx_cnt != CW'(L + 1)) rx_cnt <= rx_cnt + 1'b1;
      end
      if (fr_fall && armed) begin
        armed <= 1'b0;
        if (rx_ok) begin
          rx_valid  <= 1'b1;
          got_valid <= 1'b1;
          rx_stat   <= rx_sh[L-1 -: 2];
          rx_score  <= rx_sh[L-3 -: SCORE_W];
          rx_ko     <= rx_sh[L-3-SCORE_W];
          rx_bomb   <= rx_sh[L-4-SCORE_W -: BOMB_W];
        end else begin
          rx_err <= 1'b1;
        end
      end
      if (accept) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT)) to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule
